// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and forward controller for the 5-stage MIPS pipeline.
// Optional macro PIPE_FWD_EN: forwarding from MEM/WB with load-use-only stalls;
// without it, every RAW hazard against EXE or MEM stalls and fwd_a/fwd_b stay 00.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   id_src1/2, id_src2_used  source registers of the instruction in ID
//   exe_*                    destination, write-back, load flag and sources in EXE
//   br_taken                 branch taken, resolved in EXE
//   mem_dest/mem_wb_en       destination of the instruction in MEM
//   mem_req/mem_ready        data-memory handshake
//   wb_dest/wb_wb_en         destination of the instruction in WB
//   pc_stall .. memwb_bubble pipeline register hold/flush/bubble controls
//   fwd_a/fwd_b              EXE operand selects: 00 regfile, 01 MEM, 10 WB
//   err                      sticky memory-wait watchdog error
//   stall_count              saturating count of stalled cycles in RUN/MEM_WAIT
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_src2_used,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_src1,
    input  logic [4:0]       exe_src2,
    input  logic             br_taken,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [4:0]       wb_dest,
    input  logic             wb_wb_en,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             exe_freeze,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err,
    output logic [CNT_W-1:0] stall_count
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 2);
    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, ERROR} state_t;
    state_t state, state_nx;
    logic [BW-1:0] boot_cnt;
    logic [WW-1:0] wait_cnt;
    logic mem_stall, hazard, boot, frz, act, ex_hit;
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return a != 5'd0 && a == b;
    endfunction
    assign mem_stall = mem_req & ~mem_ready;
    assign ex_hit = hit(id_src1, exe_dest) | (id_src2_used & hit(id_src2, exe_dest));
`ifdef PIPE_FWD_EN
    function automatic logic [1:0] fsel(input logic [4:0] s);
        return hit(s, mem_dest) && mem_wb_en ? 2'b01 : hit(s, wb_dest) && wb_wb_en ? 2'b10 : 2'b00;
    endfunction
    logic unused_fwd;
    assign unused_fwd = 1'b0;
    assign hazard = exe_mem_read & exe_wb_en & ex_hit;
    assign fwd_a = boot ? 2'b00 : fsel(exe_src1);
    assign fwd_b = boot ? 2'b00 : fsel(exe_src2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{exe_mem_read, exe_src1, exe_src2, wb_dest, wb_wb_en};
    assign hazard = (exe_wb_en & ex_hit) |
                    (mem_wb_en & (hit(id_src1, mem_dest) | (id_src2_used & hit(id_src2, mem_dest))));
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif
    // Memory stalls outrank branches and data hazards; ERROR keeps the pipe frozen.
    assign boot = state == BOOT;
    assign frz = state == ERROR || (!boot && mem_stall);
    assign act = (state == RUN || state == MEM_WAIT) && !mem_stall;
    assign pc_stall = boot | frz | (act & ~br_taken & hazard);
    assign ifid_stall = frz | (act & ~br_taken & hazard);
    assign ifid_flush = boot | (act & br_taken);
    assign idexe_bubble = boot | (act & (br_taken | hazard));
    assign exe_freeze = frz;
    assign memwb_bubble = boot | frz;
    always_comb begin
        state_nx = state;
        case (state)
            BOOT:     state_nx = boot_cnt == BW'(BOOT_CYCLES - 1) ? RUN : BOOT;
            RUN:      state_nx = mem_stall ? MEM_WAIT : RUN;
            MEM_WAIT: state_nx = !mem_stall ? RUN :
                                 (MEM_TIMEOUT != 0 && wait_cnt == WW'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
            default:  state_nx = ERROR;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            boot_cnt <= '0;
            wait_cnt <= '0;
            err <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            boot_cnt <= boot ? boot_cnt + BW'(1) : boot_cnt;
            wait_cnt <= state == RUN && mem_stall ? WW'(1) :
                        state == MEM_WAIT && mem_stall && !(&wait_cnt) ? wait_cnt + WW'(1) : wait_cnt;
            err <= err | (state_nx == ERROR);
            if ((state == RUN || state == MEM_WAIT) && pc_stall && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int BC = 2;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int M_BOOT = 0, M_RUN = 1, M_WAIT = 2, M_ERR = 3;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_src1, id_src2, exe_dest, exe_src1, exe_src2, mem_dest, wb_dest;
    logic id_src2_used, exe_wb_en, exe_mem_read, br_taken, mem_wb_en, mem_req, mem_ready, wb_wb_en;
    logic pc_stall, ifid_stall, ifid_flush, idexe_bubble, exe_freeze, memwb_bubble, err;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_count;
    logic [10:0] obs, exp_o;
    int mode, boot_n, wait_n, m_cnt;
    int ncmp = 0, nfail = 0;

    pipe_hazard_ctrl #(.BOOT_CYCLES(BC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .br_taken(br_taken),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idexe_bubble(idexe_bubble), .exe_freeze(exe_freeze),
        .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .err(err),
        .stall_count(stall_count));

    always #5 clk = ~clk;
    assign obs = {pc_stall, ifid_stall, ifid_flush, idexe_bubble, exe_freeze, memwb_bubble, fwd_a, fwd_b, err};

    function automatic bit src_haz(input logic [4:0] s);
`ifdef PIPE_FWD_EN
        return s != 0 && exe_mem_read && exe_wb_en && s == exe_dest;
`else
        return s != 0 && ((exe_wb_en && s == exe_dest) || (mem_wb_en && s == mem_dest));
`endif
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] s);
`ifdef PIPE_FWD_EN
        if (s != 0 && s == mem_dest && mem_wb_en) return 2'b01;
        if (s != 0 && s == wb_dest && wb_wb_en) return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic m_reset();
        mode = M_BOOT; boot_n = 0; wait_n = 0; m_cnt = 0;
    endtask

    task automatic predict();
        bit st, hz;
        logic [1:0] fa, fb;
        st = mem_req && !mem_ready;
        hz = src_haz(id_src1) || (id_src2_used && src_haz(id_src2));
        fa = fsel(exe_src1);
        fb = fsel(exe_src2);
        if (mode == M_BOOT) exp_o = 11'b101101_00_00_0;
        else if (mode == M_ERR) exp_o = {6'b110011, fa, fb, 1'b1};
        else if (st) exp_o = {6'b110011, fa, fb, 1'b0};
        else if (br_taken) exp_o = {6'b001100, fa, fb, 1'b0};
        else if (hz) exp_o = {6'b110100, fa, fb, 1'b0};
        else exp_o = {6'b000000, fa, fb, 1'b0};
    endtask

    task automatic advance();
        bit st;
        predict();
        st = mem_req && !mem_ready;
        @(posedge clk);
        if (!rst) m_reset();
        else begin
            if ((mode == M_RUN || mode == M_WAIT) && exp_o[10] && m_cnt < (1 << CW) - 1) m_cnt++;
            case (mode)
                M_BOOT: begin boot_n++; if (boot_n == BC) mode = M_RUN; end
                M_RUN: if (st) begin mode = M_WAIT; wait_n = 1; end
                M_WAIT: if (!st) mode = M_RUN; else if (TO != 0 && wait_n == TO) mode = M_ERR; else wait_n++;
                default: mode = M_ERR;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic settle();
        #1 predict();
    endtask

    task automatic clear_inputs();
        {id_src1, id_src2, exe_dest, exe_src1, exe_src2, mem_dest, wb_dest} = '0;
        {id_src2_used, exe_wb_en, exe_mem_read, br_taken, mem_wb_en, mem_req, mem_ready, wb_wb_en} = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        m_reset();
        settle();
        ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL reset_outputs got %b want %b", obs, exp_o); end
        ncmp++; if (stall_count !== 0) begin nfail++; $display("FAIL reset_count got %0d want 0", stall_count); end
        advance();
        rst = 1'b1;
        for (int i = 0; i < BC + 1; i++) begin
            settle();
            ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL boot_cycle%0d got %b want %b", i, obs, exp_o); end
            ncmp++; if (pc_stall !== (i < BC)) begin nfail++; $display("FAIL boot_pc_stall%0d got %b want %b", i, pc_stall, i < BC); end
            advance();
        end
        ncmp++; if (stall_count !== 0) begin nfail++; $display("FAIL boot_count got %0d want 0", stall_count); end
    endtask

    task automatic test_load_use();
        int c0;
        c0 = m_cnt;
        clear_inputs();
        exe_mem_read = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3;
        settle();
        ncmp++; if (obs !== exp_o || obs[10:7] !== 4'b1101) begin nfail++; $display("FAIL load_use got %b want %b", obs, exp_o); end
        advance();
        ncmp++; if (stall_count !== CW'(c0 + 1)) begin nfail++; $display("FAIL load_use_count got %0d want %0d", stall_count, c0 + 1); end
        id_src1 = 0;
        settle();
        ncmp++; if (obs !== exp_o || pc_stall !== 1'b0) begin nfail++; $display("FAIL load_use_r0 got %b want %b", obs, exp_o); end
        advance();
        id_src1 = 7; id_src2 = 3; id_src2_used = 1;
        settle();
        ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL load_use_src2 got %b want %b", obs, exp_o); end
        advance();
    endtask

    task automatic test_branch();
        clear_inputs();
        exe_mem_read = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; br_taken = 1;
        settle();
        ncmp++; if (obs !== exp_o || {pc_stall, ifid_flush, idexe_bubble} !== 3'b011) begin nfail++; $display("FAIL branch got %b want %b", obs, exp_o); end
        advance();
    endtask

    task automatic test_mem_wait();
        int c0;
        clear_inputs();
        c0 = m_cnt;
        mem_req = 1; br_taken = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            ncmp++; if (obs !== exp_o || exe_freeze !== (i < 3)) begin nfail++; $display("FAIL mem_wait%0d got %b want %b", i, obs, exp_o); end
            advance();
        end
        ncmp++; if (stall_count !== CW'(c0 + 3)) begin nfail++; $display("FAIL mem_wait_count got %0d want %0d", stall_count, c0 + 3); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        mem_req = 1;
        for (int i = 1; i <= 8; i++) begin
            settle();
            ncmp++; if (obs !== exp_o || err !== (i >= 6)) begin nfail++; $display("FAIL timeout_cycle%0d got %b want %b", i, obs, exp_o); end
            advance();
        end
        rst = 1'b0;
        m_reset();
        settle();
        ncmp++; if (obs !== exp_o || err !== 1'b0) begin nfail++; $display("FAIL timeout_reset got %b want %b", obs, exp_o); end
        advance();
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < BC; i++) advance();
    endtask

    task automatic test_fwd();
        clear_inputs();
        exe_src1 = 5; mem_dest = 5; wb_dest = 5; mem_wb_en = 1; wb_wb_en = 1;
        settle();
        ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL fwd_mem got %b want %b", obs, exp_o); end
        mem_wb_en = 0;
        settle();
        ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL fwd_wb got %b want %b", obs, exp_o); end
        exe_src1 = 0;
        settle();
        ncmp++; if (obs !== exp_o || fwd_a !== 2'b00) begin nfail++; $display("FAIL fwd_r0 got %b want %b", obs, exp_o); end
        exe_src2 = 5; mem_wb_en = 1;
        settle();
        ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL fwd_b got %b want %b", obs, exp_o); end
        advance();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_src1 = 5'($urandom_range(0, 3)); id_src2 = 5'($urandom_range(0, 3));
            exe_dest = 5'($urandom_range(0, 3)); exe_src1 = 5'($urandom_range(0, 3));
            exe_src2 = 5'($urandom_range(0, 3)); mem_dest = 5'($urandom_range(0, 3));
            wb_dest = 5'($urandom_range(0, 3));
            {id_src2_used, exe_wb_en, exe_mem_read, mem_wb_en, wb_wb_en} = 5'($urandom);
            br_taken = $urandom_range(0, 4) == 0;
            mem_req = $urandom_range(0, 2) == 0;
            mem_ready = $urandom_range(0, 2) != 0;
            rst = $urandom_range(0, 60) != 0;
            if (!rst) m_reset();
            settle();
            ncmp++; if (obs !== exp_o) begin nfail++; $display("FAIL random%0d got %b want %b", i, obs, exp_o); end
            ncmp++; if (stall_count !== CW'(m_cnt)) begin nfail++; $display("FAIL random_count%0d got %0d want %0d", i, stall_count, m_cnt); end
            advance();
        end
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_fwd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
